// File: rtl/core_bus_pkg.sv
// Shared encodings for the core-side memory bus bridges.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts enabled cycles and flags the LIMIT-th one; the count saturates there until cleared.
// Latency: expired_o is combinational on the LIMIT-th consecutive enabled cycle.
// Backpressure: none; clear_i has priority over enable_i.
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = enable_i && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges core fetch and data ports onto one memory bus, one transaction at a time.
// Latency: request cycle 0, strobe cycle 1, response cycle N>=1, ack cycle N+1.
// Backpressure: requests are levels held until ack; the loser simply waits in IDLE.
module core_mem_arbiter
    import core_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  i_ack,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  d_ack,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_response,
    output logic                  bus_error
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    state_t                state_q;
    logic                  owner_q;
    logic [3:0]            burst_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  i_ack_q;
    logic                  d_ack_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  bus_err_q;

    logic                  d_req;
    logic                  grant_d;
    logic                  grant_i;
    logic                  expired;
    logic [DATA_WIDTH-1:0] resp_data_d;

    assign d_req   = d_read | d_write;
    // Fetch only pre-empts data once the data side has used up its burst allowance.
    assign grant_d = d_req && !(i_read && (burst_q == BURST_MAX));
    assign grant_i = i_read && !grant_d;

    always_comb begin
        resp_data_d = '0;
        if (mem_response) begin
            resp_data_d = mem_write_q ? '0 : mem_read_data;
        end else begin
            resp_data_d = ERR_DATA;
        end
    end

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (state_q == BUSY),
        .clear_i   (state_q != BUSY),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_I;
            burst_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        owner_q     <= grant_d ? OWNER_D : OWNER_I;
                        addr_q      <= grant_d ? d_address : i_address;
                        wdata_q     <= grant_d ? d_write_data : '0;
                        mem_write_q <= grant_d && d_write;
                        mem_read_q  <= !(grant_d && d_write);
                        state_q     <= BUSY;
                        if (grant_i) begin
                            burst_q <= '0;
                        end else if (i_read && (burst_q != BURST_MAX)) begin
                            burst_q <= burst_q + 4'd1;
                        end
                    end
                end
                BUSY: begin
                    // A response in the expiry cycle still counts as a normal completion.
                    if (mem_response || expired) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= RESP;
                        if (!mem_response) begin
                            bus_err_q <= 1'b1;
                        end
                        if (owner_q == OWNER_D) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= resp_data_d;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= resp_data_d;
                        end
                    end
                end
                RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    i_ack_q     <= 1'b0;
                    d_ack_q     <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign i_ack          = i_ack_q;
    assign d_ack          = d_ack_q;
    assign i_read_data    = i_rdata_q;
    assign d_read_data    = d_rdata_q;
    assign bus_error      = bus_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed and randomized bench for core_mem_arbiter with a rule-level arbitration model.
module tb_core_mem_arbiter;

    localparam int MAXB = 4;
    localparam int TO   = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_read_data;
    logic        i_ack;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_write_data;
    logic [31:0] d_read_data;
    logic        d_ack;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;
    logic        bus_error;

    int          checks   = 0;
    int          failures = 0;
    int          burst_m  = 0;
    logic [31:0] last_i   = '0;
    logic [31:0] last_d   = '0;
    logic        berr_m   = 1'b0;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MAX_DATA_BURST (MAXB),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_read         (i_read),
        .i_address      (i_address),
        .i_read_data    (i_read_data),
        .i_ack          (i_ack),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_write_data   (d_write_data),
        .d_read_data    (d_read_data),
        .d_ack          (d_ack),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_response   (mem_response),
        .bus_error      (bus_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_read"}, mem_read, 1'b0);
        check({tag, "_mem_write"}, mem_write, 1'b0);
        check({tag, "_i_ack"}, i_ack, 1'b0);
        check({tag, "_d_ack"}, d_ack, 1'b0);
        check({tag, "_bus_error"}, bus_error, berr_m);
    endtask

    // Starts in IDLE with requests applied; response in BUSY cycle n, or no response when to=1.
    task automatic xact(input int n, input bit to, input logic [31:0] rdata, input bit drop);
        bit          own_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_data;
        own_d = (d_read || d_write) && !(burst_m == MAXB && i_read);
        if (own_d) begin
            if (i_read && burst_m < MAXB) burst_m++;
        end else begin
            burst_m = 0;
        end
        wr   = own_d && d_write;
        addr = own_d ? d_address : i_address;
        wd   = d_write_data;
        tick();
        for (int k = 1; k <= n; k++) begin
            check("busy_mem_read", mem_read, !wr);
            check("busy_mem_write", mem_write, wr);
            check("busy_mem_address", mem_address, addr);
            if (wr) check("busy_mem_write_data", mem_write_data, wd);
            check("busy_i_ack", i_ack, 1'b0);
            check("busy_d_ack", d_ack, 1'b0);
            if (!to && k == n) begin
                mem_response  = 1'b1;
                mem_read_data = rdata;
            end
            tick();
            mem_response  = 1'b0;
            mem_read_data = $urandom;
        end
        if (to) berr_m = 1'b1;
        exp_data = to ? ERR : (wr ? 32'h0 : rdata);
        if (own_d) last_d = exp_data;
        else       last_i = exp_data;
        check("resp_mem_read", mem_read, 1'b0);
        check("resp_mem_write", mem_write, 1'b0);
        check("resp_i_ack", i_ack, !own_d);
        check("resp_d_ack", d_ack, own_d);
        check("resp_i_read_data", i_read_data, last_i);
        check("resp_d_read_data", d_read_data, last_d);
        check("resp_bus_error", bus_error, berr_m);
        if (drop) begin
            if (own_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
        end
        tick();
        check_quiet("post");
        check("post_i_read_data", i_read_data, last_i);
        check("post_d_read_data", d_read_data, last_d);
    endtask

    initial begin
        int kind;
        bit to;
        reset = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_write_data = '0;
        mem_read_data = '0; mem_response = 1'b0;
        #3;
        check_quiet("reset");
        check("reset_i_read_data", i_read_data, 32'h0);
        check("reset_d_read_data", d_read_data, 32'h0);
        tick(); tick();
        @(negedge clk) reset = 1'b0;
        tick();
        check_quiet("idle");

        // Fetch only, response in the third BUSY cycle.
        i_address = 32'h100; i_read = 1'b1;
        xact(3, 1'b0, 32'h00000013, 1'b1);

        // Simultaneous requests: data first, then fetch.
        i_address = 32'h200; d_address = 32'h300;
        i_read = 1'b1; d_read = 1'b1;
        xact(2, 1'b0, 32'hA1A1A1A1, 1'b1);
        xact(1, 1'b0, 32'hB2B2B2B2, 1'b1);

        // Starvation: data held, fetch waits for four data grants; twice to show the count restarts.
        d_address = 32'h400; d_read = 1'b1;
        for (int r = 0; r < 2; r++) begin
            i_address = 32'h500 + r; i_read = 1'b1;
            for (int g = 0; g < MAXB; g++) xact(1, 1'b0, $urandom, 1'b0);
            check("starve_burst_full", burst_m, MAXB);
            xact(1, 1'b0, 32'h600 + r, 1'b1);
            check("starve_fetch_served", i_read_data, 32'h600 + r);
        end
        d_read = 1'b0;
        tick();
        check_quiet("starve_end");

        // Write with response in the first BUSY cycle.
        d_write = 1'b1; d_address = 32'h2000; d_write_data = 32'hCAFEF00D;
        xact(1, 1'b0, 32'h12345678, 1'b1);

        // Timeout, then a stray response in IDLE.
        d_read = 1'b1; d_address = 32'h40;
        xact(TO, 1'b1, 32'h0, 1'b1);
        mem_response = 1'b1; mem_read_data = 32'h55555555;
        tick();
        mem_response = 1'b0;
        check_quiet("late_resp");
        tick();
        check_quiet("late_resp2");
        check("late_d_read_data", d_read_data, ERR);
        i_address = 32'h700; i_read = 1'b1;
        xact(2, 1'b0, 32'h77777777, 1'b1);

        // Reset while BUSY.
        d_read = 1'b1; d_address = 32'h80;
        tick();
        check("rst_busy_mem_read", mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_mem_read", mem_read, 1'b0);
        d_read = 1'b0;
        burst_m = 0; last_i = '0; last_d = '0; berr_m = 1'b0;
        check("rst_bus_error", bus_error, 1'b0);
        tick();
        @(negedge clk) reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_quiet("rst_after");
        end
        i_address = 32'h900; i_read = 1'b1;
        xact(1, 1'b0, 32'h99999999, 1'b1);

        // Randomized traffic with protocol-compliant requesters.
        for (int it = 0; it < 80; it++) begin
            if (!i_read && $urandom_range(0, 1) == 1) begin
                i_read = 1'b1; i_address = $urandom;
            end
            if (!(d_read || d_write) && $urandom_range(0, 1) == 1) begin
                kind = $urandom_range(0, 2);
                d_read  = (kind != 1);
                d_write = (kind != 0);
                d_address = $urandom; d_write_data = $urandom;
            end
            if (i_read || d_read || d_write) begin
                to = ($urandom_range(0, 9) == 0);
                xact(to ? TO : $urandom_range(1, 4), to, $urandom, 1'b1);
            end else begin
                tick();
                check_quiet("rand_idle");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
